// File: rtl/tinytpu_operand_tx.sv
// ---------------------------------------------------------------------------
// tinytpu_operand_lane
//   One serial channel (X or Y) of the operand transmitter: a WORD-deep
//   element buffer plus the registered serial output bit.
//   clk, rst_n   clock / async active-low reset
//   we_i         write element wdata_i into slot waddr_i
//   shift_i      next cycle drives a valid bit (else the line is held at 0)
//   relem_i      element index of the next bit
//   rbit_i       bit position of the next bit inside that element
//   sdata_o      registered serial bit to the core
// ---------------------------------------------------------------------------
module tinytpu_operand_lane #(
  parameter int D_W  = 8,
  parameter int WORD = 4,
  parameter int EW   = 2,
  parameter int BW   = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we_i,
  input  logic [EW-1:0]  waddr_i,
  input  logic [D_W-1:0] wdata_i,
  input  logic           shift_i,
  input  logic [EW-1:0]  relem_i,
  input  logic [BW-1:0]  rbit_i,
  output logic           sdata_o
);
  logic [D_W-1:0] mem_q [WORD];
  logic [D_W-1:0] word_sel;
  logic           sdata_d, sdata_q;

  // Buffer contents are don't-care whenever fill is 0, so no reset here.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Forward the element being written on the same edge; only reachable when
  // WORD == 1, where the accepting edge also launches element 0.
  always_comb begin
    word_sel = mem_q[relem_i];
    if (we_i && (waddr_i == relem_i)) word_sel = wdata_i;
    sdata_d = shift_i & word_sel[rbit_i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sdata_q <= 1'b0;
    else        sdata_q <= sdata_d;
  end

  assign sdata_o = sdata_q;
endmodule

// ---------------------------------------------------------------------------
// tinytpu_operand_tx
//   Collects WORD (X,Y) operand pairs over a valid/ready push port, then
//   replays them bit-serially (element 0 first, MSB-first) on the tinytpu
//   load lines, followed by a one-cycle init strobe.
//   clk, rst_n          clock / async active-low reset
//   in_valid/in_ready   push handshake, in_x/in_y the pair
//   data_in_x/_y        serial bits (registered, 0 outside SHIFT)
//   load_en             high while serial bits are valid
//   init                one-cycle strobe after the last bit
//   busy                high in SHIFT and INIT
//   fill                pairs buffered
// ---------------------------------------------------------------------------
module tinytpu_operand_tx #(
  parameter int D_W  = 8,
  parameter int N    = 2,
  parameter int WORD = N * N
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [D_W-1:0]            in_x,
  input  logic [D_W-1:0]            in_y,
  output logic                      data_in_x,
  output logic                      data_in_y,
  output logic                      load_en,
  output logic                      init,
  output logic                      busy,
  output logic [$clog2(WORD+1)-1:0] fill
);
  localparam int FW = $clog2(WORD + 1);
  localparam int EW = (WORD > 1) ? $clog2(WORD) : 1;
  localparam int BW = (D_W > 1) ? $clog2(D_W) : 1;
  localparam int NL = 2;  // lane 0 = X, lane 1 = Y

  localparam logic [FW-1:0] FILL_MAX  = FW'(WORD);
  localparam logic [FW-1:0] FILL_LAST = FW'(WORD - 1);
  localparam logic [EW-1:0] ELEM_LAST = EW'(WORD - 1);
  localparam logic [BW-1:0] BIT_MSB   = BW'(D_W - 1);

  typedef enum logic [1:0] {COLLECT, SHIFT, INIT} state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  // The WORD*D_W bit counter is kept split as (element, bit position):
  // element counts up, bit position counts down for MSB-first order.
  logic [EW-1:0] elem_q, elem_d;
  logic [BW-1:0] bpos_q, bpos_d;
  logic          load_en_q, load_en_d;
  logic          init_q, init_d;
  logic          busy_q, busy_d;
  logic          acc;

  logic [NL-1:0][D_W-1:0] lane_wdata;
  logic [NL-1:0]          lane_sdata;

  assign in_ready = (state_q == COLLECT) && (fill_q < FILL_MAX);
  assign acc      = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      fill_q    <= '0;
      elem_q    <= '0;
      bpos_q    <= '0;
      load_en_q <= 1'b0;
      init_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      elem_q    <= elem_d;
      bpos_q    <= bpos_d;
      load_en_q <= load_en_d;
      init_q    <= init_d;
      busy_q    <= busy_d;
    end
  end

  // *_d values describe the cycle after the edge; elem_d/bpos_d address the
  // bit the lanes register on that same edge.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    elem_d    = elem_q;
    bpos_d    = bpos_q;
    load_en_d = 1'b0;
    init_d    = 1'b0;
    busy_d    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (acc) begin
          fill_d = fill_q + 1'b1;
          if (fill_q == FILL_LAST) begin
            state_d   = SHIFT;
            load_en_d = 1'b1;
            busy_d    = 1'b1;
            elem_d    = '0;
            bpos_d    = BIT_MSB;
          end
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        if ((elem_q == ELEM_LAST) && (bpos_q == '0)) begin
          state_d = INIT;
          init_d  = 1'b1;
        end else begin
          load_en_d = 1'b1;
          if (bpos_q == '0) begin
            bpos_d = BIT_MSB;
            elem_d = elem_q + 1'b1;
          end else begin
            bpos_d = bpos_q - 1'b1;
          end
        end
      end
      INIT: begin
        state_d = COLLECT;
        fill_d  = '0;
      end
      default: begin
        state_d = COLLECT;
        fill_d  = '0;
      end
    endcase
  end

  assign lane_wdata = {in_y, in_x};

  for (genvar l = 0; l < NL; l++) begin : g_lane
    tinytpu_operand_lane #(
      .D_W (D_W),
      .WORD(WORD),
      .EW  (EW),
      .BW  (BW)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .we_i   (acc),
      .waddr_i(fill_q[EW-1:0]),
      .wdata_i(lane_wdata[l]),
      .shift_i(load_en_d),
      .relem_i(elem_d),
      .rbit_i (bpos_d),
      .sdata_o(lane_sdata[l])
    );
  end

  assign data_in_x = lane_sdata[0];
  assign data_in_y = lane_sdata[1];
  assign load_en   = load_en_q;
  assign init      = init_q;
  assign busy      = busy_q;
  assign fill      = fill_q;
endmodule

// File: tb/tb_tinytpu_operand_tx.sv
// Directed bench for tinytpu_operand_tx: default instance (D_W=8, WORD=4)
// plus a D_W=4, N=3 instance for the parameter sweep.
module tb_tinytpu_operand_tx;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] in_x, in_y;
  logic       data_in_x, data_in_y, load_en, init, busy;
  logic [2:0] fill;

  logic       b_in_valid, b_in_ready;
  logic [3:0] b_in_x, b_in_y;
  logic       b_dx, b_dy, b_load_en, b_init, b_busy;
  logic [3:0] b_fill;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tinytpu_operand_tx dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .data_in_x(data_in_x), .data_in_y(data_in_y),
    .load_en(load_en), .init(init), .busy(busy), .fill(fill)
  );

  tinytpu_operand_tx #(.D_W(4), .N(3), .WORD(9)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_x(b_in_x), .in_y(b_in_y), .data_in_x(b_dx), .data_in_y(b_dy),
    .load_en(b_load_en), .init(b_init), .busy(b_busy), .fill(b_fill)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- frame monitor (default instance), sampled on negedges ----
  int          cyc = 0;
  int          nframes = 0;
  logic [63:0] acx = '0, acy = '0;
  int          nle = 0, rise_t = 0;
  logic        in_le = 1'b0;
  logic [63:0] fx = '0, fy = '0, px = '0, py = '0;
  int          fn = 0, ft = 0, pt = 0, frise = 0;
  logic        fbusy = 1'b0, fser = 1'b0;
  int          both_hi = 0, bad_fill = 0, bad_rdy = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!busy) begin
      acx <= '0; acy <= '0; nle <= 0; in_le <= 1'b0;
    end else begin
      in_le <= load_en;
      if (load_en) begin
        if (!in_le) rise_t <= cyc;
        acx <= {acx[62:0], data_in_x};
        acy <= {acy[62:0], data_in_y};
        nle <= nle + 1;
      end
      if (fill != 3'd4) bad_fill <= bad_fill + 1;
      if (in_ready)     bad_rdy  <= bad_rdy + 1;
    end
    if (load_en && init) both_hi <= both_hi + 1;
    if (init) begin
      px <= fx; py <= fy; pt <= ft;
      fx <= acx; fy <= acy; fn <= nle; ft <= cyc; frise <= rise_t;
      fbusy <= busy; fser <= data_in_x | data_in_y;
      nframes <= nframes + 1;
    end
  end

  // ---- sweep-instance monitor ----
  logic [63:0] bacx = '0, bacy = '0, bfx = '0, bfy = '0;
  int          bnle = 0, bfn = 0, b_nfr = 0;

  always @(negedge clk) begin
    if (!b_busy) begin
      bacx <= '0; bacy <= '0; bnle <= 0;
    end
    if (b_load_en) begin
      bacx <= {bacx[62:0], b_dx};
      bacy <= {bacy[62:0], b_dy};
      bnle <= bnle + 1;
    end
    if (b_init) begin
      bfx <= bacx; bfy <= bacy; bfn <= bnle; b_nfr <= b_nfr + 1;
    end
  end

  int t_acc = 0;

  // Called just after a negedge; returns on the negedge after the accept edge
  // with in_valid still high.
  task automatic push(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    in_valid = 1'b1; in_x = x; in_y = y;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", 1'b0, 1'b1);
    t_acc = cyc;
    @(negedge clk);
  endtask

  task automatic push_frame(input logic [31:0] xs, input logic [31:0] ys, input int gap);
    for (int i = 0; i < 4; i++) begin
      push(xs[31-8*i -: 8], ys[31-8*i -: 8]);
      if (gap > 0 && i < 3) begin
        in_valid = 1'b0;
        chk($sformatf("gap_fill%0d", i), fill, 3'(i + 1));
        repeat (gap) @(negedge clk);
        chk($sformatf("gap_hold%0d", i), fill, 3'(i + 1));
      end
    end
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (nframes < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (nframes < target) chk("frame_timeout", 64'(nframes), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n;
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0;
    b_in_valid = 1'b0; b_in_x = '0; b_in_y = '0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_load_en", load_en, 1'b0);
    chk("rst_init", init, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_serial", {data_in_x, data_in_y}, 2'b00);
    chk("rst_fill", fill, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // asynchronous reset at bit 10 of SHIFT
    n0 = nframes;
    push_frame(32'h12345678, 32'h9ABCDEF0, 0);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_load_en", load_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_load_en", load_en, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_fill", fill, 3'd0);
    chk("arst_init_ser", {init, data_in_x, data_in_y}, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_fill", fill, 3'd0);
    chk("post_rst_ready", in_ready, 1'b1);
    chk("post_rst_noinit", 64'(nframes), 64'(n0));

    // single frame, back-to-back pushes
    n0 = nframes;
    push_frame(32'h12345678, 32'h9ABCDEF0, 0);
    in_valid = 1'b0;
    wait_frames(n0 + 1);
    chk("sf_x_byte0", fx[31:24], 8'b0001_0010);
    chk("sf_y_byte0", fy[31:24], 8'b1001_1010);
    chk("sf_x_stream", fx, 64'h12345678);
    chk("sf_y_stream", fy, 64'h9ABCDEF0);
    chk("sf_load_cycles", 64'(fn), 64'd32);
    chk("sf_rise", 64'(frise - t_acc), 64'd1);
    chk("sf_init_latency", 64'(ft - t_acc), 64'd33);
    chk("sf_init_busy_ser", {fbusy, fser}, 2'b10);
    @(negedge clk);
    chk("sf_after_init", {init, busy, in_ready}, 3'b001);
    chk("sf_after_fill", fill, 3'd0);

    // gapped input
    n0 = nframes;
    push_frame(32'h12345678, 32'h9ABCDEF0, 3);
    in_valid = 1'b0;
    wait_frames(n0 + 1);
    chk("gap_x_stream", fx, 64'h12345678);
    chk("gap_y_stream", fy, 64'h9ABCDEF0);
    chk("gap_rise", 64'(frise - t_acc), 64'd1);
    @(negedge clk);

    // pushes held through SHIFT and INIT are ignored
    n0 = nframes;
    push_frame(32'hC0FFEE11, 32'h0BADF00D, 0);
    repeat (33) begin
      in_x = 8'($urandom); in_y = 8'($urandom);
      @(negedge clk);
    end
    chk("ign_fill_cleared", fill, 3'd0);
    push_frame(32'h11223344, 32'h55667788, 0);
    in_valid = 1'b0;
    wait_frames(n0 + 2);
    chk("ign_x1", px, 64'hC0FFEE11);
    chk("ign_y1", py, 64'h0BADF00D);
    chk("ign_x2", fx, 64'h11223344);
    chk("ign_y2", fy, 64'h55667788);
    @(negedge clk);

    // back-to-back frames with continuous in_valid
    n0 = nframes;
    push_frame(32'hFF00A55A, 32'h11223344, 0);
    push_frame(32'h01020304, 32'hAABBCCDD, 0);
    in_valid = 1'b0;
    wait_frames(n0 + 2);
    chk("b2b_x1", px, 64'hFF00A55A);
    chk("b2b_x2", fx, 64'h01020304);
    chk("b2b_y2", fy, 64'hAABBCCDD);
    chk("b2b_period", 64'(ft - pt), 64'd37);
    chk("b2b_load_cycles", 64'(fn), 64'd32);
    @(negedge clk);

    chk("load_init_overlap", 64'(both_hi), 64'd0);
    chk("busy_fill_held", 64'(bad_fill), 64'd0);
    chk("busy_not_ready", 64'(bad_rdy), 64'd0);

    // parameter sweep instance: D_W=4, WORD=9
    b_in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      b_in_x = 4'(i + 1);
      b_in_y = 4'(15 - i);
      @(negedge clk);
      if (i == 7) chk("sw_fill8", b_fill, 4'd8);
    end
    b_in_valid = 1'b0;
    chk("sw_fill9", b_fill, 4'd9);
    chk("sw_load_en", b_load_en, 1'b1);
    n = 0;
    while (b_nfr < 1 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("sw_frames", 64'(b_nfr), 64'd1);
    chk("sw_x_stream", bfx, 64'h123456789);
    chk("sw_y_stream", bfy, 64'hFEDCBA987);
    chk("sw_load_cycles", 64'(bfn), 64'd36);
    @(negedge clk);
    chk("sw_after", {b_busy, b_in_ready, b_fill}, {2'b01, 4'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
